// File: rtl/fp_decode_serial_pkg.sv
// Shared constants for the float<->linear converter pair: default field widths
// and the decoder FSM state encodings.
package fp_decode_serial_pkg;

    localparam int DEF_EXP_W = 3;
    localparam int DEF_SIG_W = 4;
    localparam int DEF_OUT_W = 12;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/fp_sign_apply.sv
// Combinational conditional two's-complement negate of a W-bit value.
module fp_sign_apply #(
    parameter int W = 12
) (
    input  logic         neg,
    input  logic [W-1:0] mag,
    output logic [W-1:0] res
);

    assign res = neg ? -mag : mag;

endmodule

// File: rtl/fp_decode_serial.sv
// Serial float->linear expander: loads the significand, shifts it left once per
// clock for exp steps, then presents the signed result until the consumer takes it.
module fp_decode_serial
    import fp_decode_serial_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int SIG_W = DEF_SIG_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [SIG_W-1:0] in_sig,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             busy
);

    state_t           state;
    logic [OUT_W-2:0] acc;
    logic [EXP_W-1:0] cnt;
    logic             sgn;
    logic [OUT_W-1:0] signed_val;

    // The magnitude occupies OUT_W-1 bits, so the negate can never overflow.
    fp_sign_apply #(.W(OUT_W)) u_sign_apply (
        .neg (sgn),
        .mag ({1'b0, acc}),
        .res (signed_val)
    );

    // NOTE: state registers use non-blocking assignments so every branch sees
    // the pre-edge values of acc/cnt regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            acc       <= '0;
            cnt       <= '0;
            sgn       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        acc   <= {{(OUT_W-1-SIG_W){1'b0}}, in_sig};
                        cnt   <= in_exp;
                        sgn   <= in_sign;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cnt != '0) begin
                        acc <= acc << 1;
                        cnt <= cnt - EXP_W'(1);
                    end else begin
                        out_data  <= signed_val;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready = (state == ST_IDLE);
    assign busy     = (state == ST_SHIFT) || (state == ST_DONE);

endmodule

// File: tb/tb_fp_decode_serial.sv
// Bench for fp_decode_serial: directed vectors with literal results, a stall in
// DONE, a mid-shift reset and an exhaustive round trip against a value model.
module tb_fp_decode_serial;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [2:0]  in_exp = '0;
    logic [3:0]  in_sig = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] out_data;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;
    bit mon_en  = 1'b0;

    // Transaction-level model: pending result, cycles until it shows, its value.
    bit          m_pend = 1'b0;
    int          m_cnt  = 0;
    logic [11:0] m_val  = '0;

    fp_decode_serial dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_sig    (in_sig),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] model(input bit s, input int e, input int g);
        int m;
        m = g * (1 << e);
        return s ? 12'(-m) : 12'(m);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk) begin
        bit was_pend;
        int was_cnt;
        was_pend = m_pend;
        was_cnt  = m_cnt;
        if (rst) begin
            m_pend = 1'b0;
            m_cnt  = 0;
        end else begin
            if (was_pend && was_cnt > 0) m_cnt = was_cnt - 1;
            if (was_pend && was_cnt == 0 && out_ready) m_pend = 1'b0;
            if (!was_pend && in_valid) begin
                m_pend = 1'b1;
                m_cnt  = int'(in_exp) + 1;
                m_val  = model(in_sign, int'(in_exp), int'(in_sig));
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("mon_in_ready", 32'(in_ready), 32'(!m_pend));
            check("mon_busy", 32'(busy), 32'(m_pend));
            check("mon_out_valid", 32'(out_valid), 32'(m_pend && m_cnt == 0));
            if (m_pend && m_cnt == 0) check("mon_out_data", 32'(out_data), 32'(m_val));
        end
    end

    // Called at a negedge; returns at a negedge with the block idle again.
    task automatic op(input bit s, input int e, input int g, input int hold,
                      input bit use_lit, input logic [11:0] lit);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 32'(n < 40), 32'd1);
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = 3'(e);
        in_sig   = 4'(g);
        @(negedge clk);
        in_valid = 1'b0;
        in_sign  = 1'($urandom);
        in_exp   = 3'($urandom);
        in_sig   = 4'($urandom);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(e + 1));
        if (use_lit) check("lit_data", 32'(out_data), 32'(lit));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_sig   = 4'($urandom);
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_ready", 32'(in_ready), 32'd0);
            check("hold_data", 32'(out_data), 32'(lit));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        op(1'b0, 0, 5, 0, 1'b1, 12'd5);
        op(1'b0, 5, 13, 0, 1'b1, 12'h1A0);
        op(1'b1, 7, 15, 0, 1'b1, 12'h880);
        op(1'b1, 4, 0, 0, 1'b1, 12'h000);
        op(1'b0, 2, 3, 0, 1'b1, 12'd12);
        op(1'b1, 2, 5, 3, 1'b1, 12'hFEC);

        // Reset three cycles into a long shift discards the in-flight result.
        in_valid = 1'b1;
        in_sign  = 1'b0;
        in_exp   = 3'd7;
        in_sig   = 4'd9;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        op(1'b0, 3, 9, 0, 1'b1, 12'd72);

        for (int code = 0; code < 256; code++) begin
            logic [7:0] c;
            c = 8'(code);
            op(c[7], int'(c[6:4]), int'(c[3:0]), 0, 1'b0, 12'h000);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "timeout");
    end

endmodule
